// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared definitions for the instruction fetch unit.
//   WORD_W           : instruction / address word width (16)
//   RESET_IP_DEFAULT : default instruction pointer after reset
//   state_t          : fetch FSM encoding. ST_FAULT exists only when the
//                      FETCH_TIMEOUT_EN macro is defined.
package fetch_unit_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_IP_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_VALID = 2'd1,
    ST_HALT  = 2'd2
`ifdef FETCH_TIMEOUT_EN
    ,
    ST_FAULT = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit -- single-issue instruction fetch stage.
//
// Requests the word at ip, holds it (instr/ip, instr_valid) until the execute
// stage signals advance, then either follows next_ip or, with halt_req, parks
// in a sticky HALT state. retired counts accepted advances (wraps silently).
//
// Handshake: in REQ, mem_req=1 and a cycle with mem_ack=1 delivers mem_rdata.
// In VALID, instr_valid=1 and a cycle with advance=1 consumes the held word.
// mem_ack is ignored outside REQ; advance/halt_req are ignored outside VALID.
//
// Configuration macro: FETCH_TIMEOUT_EN
//   defined   : a REQ that waits TIMEOUT_CYCLES ack-less cycles and still
//               gets no ack enters a sticky FAULT state (fault=1).
//   undefined : REQ waits forever; fault is constant 0.
//
// Ports
//   clk, rst            clock, async active-high reset
//   mem_req, mem_addr   instruction memory request / address (= ip)
//   mem_ack, mem_rdata  memory response
//   ip, instr           held instruction address / word
//   instr_valid         instr/ip are stable and consumable
//   advance, next_ip    execute stage done, next instruction address
//   halt_req            stop after the current instruction
//   halted, retired     HALT indicator, accepted-advance count
//   fault               memory timeout indicator
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_IP       = RESET_IP_DEFAULT,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] ip,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  input  logic              advance,
  input  logic [WORD_W-1:0] next_ip,
  input  logic              halt_req,
  output logic              halted,
  output logic [WORD_W-1:0] retired,
  output logic              fault
);

  state_t state;

  // The address bus is the instruction pointer itself.
  assign mem_addr = ip;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [WORD_W-1:0] TIMEOUT_LIM = WORD_W'(TIMEOUT_CYCLES);
  logic [WORD_W-1:0] wait_cnt;
`else
  // The limit has no meaning without the timeout; it is folded into a term
  // that is always zero so fault stays a constant.
  localparam logic TIMEOUT_SEEN = (TIMEOUT_CYCLES > 0);
  assign fault = 1'b0 & TIMEOUT_SEEN;
`endif

  // Status outputs are registered alongside the state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_REQ;
      ip          <= RESET_IP;
      instr       <= '0;
      retired     <= '0;
      mem_req     <= 1'b1;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fault       <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_REQ: begin
          if (mem_ack) begin
            instr       <= mem_rdata;
            state       <= ST_VALID;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          // The counter holds the number of ack-less cycles already seen;
          // one more miss once it has reached the limit is a timeout.
          else if (wait_cnt == TIMEOUT_LIM) begin
            state   <= ST_FAULT;
            mem_req <= 1'b0;
            fault   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        ST_VALID: begin
          if (advance) begin
            retired     <= retired + 1'b1;
            instr_valid <= 1'b0;
            if (halt_req) begin
              // ip stays on the last executed instruction.
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              ip      <= next_ip;
              state   <= ST_REQ;
              mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end
          end
        end

        ST_HALT: begin
          state <= ST_HALT;
        end

`ifdef FETCH_TIMEOUT_EN
        ST_FAULT: begin
          state <= ST_FAULT;
        end
`endif

        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit (RESET_IP=16'h3000,
// TIMEOUT_CYCLES=4). Inputs are driven and outputs sampled on the falling
// edge. A phase model (fetching / holding / halted / faulted) predicts the
// status outputs, ip and retired; each delivered memory word is queued as
// {address, data} and popped by an independent monitor whenever instr_valid
// rises. Honours FETCH_TIMEOUT_EN to add the timeout scenario.
module tb_fetch_unit;

  localparam logic [15:0] RIP        = 16'h3000;
  localparam int          TB_TIMEOUT = 4;
`ifdef FETCH_TIMEOUT_EN
  localparam int STALL = 3;   // stay below the timeout in ordinary traffic
`else
  localparam int STALL = 10;
`endif

  localparam int P_FETCH = 0;
  localparam int P_HOLD  = 1;
  localparam int P_HALT  = 2;
  localparam int P_FAULT = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        advance = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] next_ip = '0;
  logic        mem_req, instr_valid, halted, fault;
  logic [15:0] mem_addr, ip, instr, retired;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_IP(RIP), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ip(ip), .instr(instr), .instr_valid(instr_valid),
    .advance(advance), .next_ip(next_ip), .halt_req(halt_req),
    .halted(halted), .retired(retired), .fault(fault)
  );

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b1;
  logic [31:0] exp_q[$];      // {ip, instr} of each delivered word
  int          ph;
  logic [15:0] m_ip;
  logic [15:0] m_retired;
  int          m_wait;
  bit          prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (chk_en) begin
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Monitor: every rising instr_valid must present the oldest delivered word.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          check("held_word", {ip, instr}, exp_q.pop_front());
        end
      end
      prev_valid = instr_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: compare outputs with the model, apply the inputs to the model,
  // drive them, then move to the next falling edge.
  task automatic tick(input bit ack, input bit adv, input bit hreq,
                      input logic [15:0] nip, input logic [15:0] rdata);
    check("mem_req", 32'(mem_req), 32'(ph == P_FETCH));
    check("instr_valid", 32'(instr_valid), 32'(ph == P_HOLD));
    check("halted", 32'(halted), 32'(ph == P_HALT));
    check("fault", 32'(fault), 32'(ph == P_FAULT));
    check("ip", 32'(ip), 32'(m_ip));
    check("mem_addr", 32'(mem_addr), 32'(m_ip));
    check("retired", 32'(retired), 32'(m_retired));
    case (ph)
      P_FETCH: begin
        if (ack) begin
          exp_q.push_back({m_ip, rdata});
          ph = P_HOLD;
          m_wait = 0;
        end else begin
          m_wait++;
`ifdef FETCH_TIMEOUT_EN
          if (m_wait > TB_TIMEOUT) ph = P_FAULT;
`endif
        end
      end
      P_HOLD: begin
        if (adv) begin
          m_retired = m_retired + 16'd1;
          if (hreq) ph = P_HALT;
          else begin
            m_ip = nip;
            ph = P_FETCH;
          end
        end
      end
      default: ;
    endcase
    mem_ack   = ack;
    advance   = adv;
    halt_req  = hreq;
    next_ip   = nip;
    mem_rdata = rdata;
    @(negedge clk);
  endtask

  // Reset asserted off the clock edge (checks the asynchronous path), with a
  // memory ack pending that must be discarded.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    advance = 1'b0;
    halt_req = 1'b0;
    #1;
    check("rst_ip", 32'(ip), 32'(RIP));
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_retired", 32'(retired), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h1);
    repeat (2) @(negedge clk);
    exp_q.delete();
    ph = P_FETCH;
    m_ip = RIP;
    m_retired = 16'h0000;
    m_wait = 0;
    rst = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ph = P_FETCH;
    m_ip = RIP;
    m_retired = '0;
    m_wait = 0;
    do_reset();

    // First fetch at RESET_IP, then an advance to 16'h3005.
    tick(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234);
    check("first_instr", 32'(instr), 32'h1234);
    tick(1'b0, 1'b1, 1'b0, 16'h3005, 16'h0000);
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("retired_one", 32'(retired), 32'h1);

    // Memory stall, then ack.
    repeat (STALL - 1) tick(1'b0, 1'b0, 1'b0, 16'h0000, 16'($urandom));
    tick(1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A);
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Random traffic; ack/advance/halt_req also toggle in phases that ignore them.
    for (int i = 0; i < 400; i++) begin
      bit ack, adv, hreq;
      ack = ($urandom_range(0, 1) == 1) || (ph == P_FETCH && m_wait >= 3);
      adv = ($urandom_range(0, 2) == 0);
      hreq = (ph != P_HOLD) && ($urandom_range(0, 1) == 1);
      tick(ack, adv, hreq, 16'($urandom), 16'($urandom));
    end

    // Halt: advance with halt_req, then 20 cycles of ignored activity.
    for (int k = 0; k < 10 && ph != P_HOLD; k++)
      tick(1'b1, 1'b0, 1'b0, 16'h0000, 16'($urandom));
    check("reached_hold", 32'(ph), 32'(P_HOLD));
    tick(1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h0000);
    for (int k = 0; k < 20; k++)
      tick(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));

    // retired wrap: 65535 unchecked instructions, then one more.
    do_reset();
    chk_en = 1'b0;
    for (int n = 0; n < 65535; n++) begin
      tick(1'b1, 1'b0, 1'b0, 16'h0000, 16'(n));
      tick(1'b0, 1'b1, 1'b0, 16'(RIP + 16'(n)), 16'h0000);
    end
    chk_en = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 16'h0000, 16'h7777);
    check("retired_ffff", 32'(retired), 32'hFFFF);
    tick(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000);
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("retired_wrap", 32'(retired), 32'h0000);

`ifdef FETCH_TIMEOUT_EN
    // Timeout: withhold ack; fault after TB_TIMEOUT+1 request cycles.
    do_reset();
    repeat (8) tick(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("fault_set", 32'(fault), 32'h1);
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("fault_cleared_addr", 32'(mem_addr), 32'(RIP));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
